servo_setpoint_encoder: RTL and testbench

SERVO_SETPOINT_ENCODER -- requirements
Module: servo_setpoint_encoder

---
 rtl/servo_setpoint_encoder.sv | 223 ++++++++++++++++++++++
 tb/tb_servo_setpoint_encoder.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_setpoint_encoder.sv
// Servo setpoint encoder: debounced quadrature encoder plus a push button that toggles
// an automatic 0..MAX_POS sweep, producing a saturated 8-bit setpoint for the PWM stage.

module servo_setpoint_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int MAX_POS         = 40,
    parameter int CENTER          = 20,
    parameter int SWEEP_DIV       = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       btn,
    output logic [7:0] position,
    output logic       pos_changed,
    output logic       sweep_active,
    output logic       enc_error
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW_W = $clog2(SWEEP_DIV);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE     = DB_W'(32'd1);
    localparam logic [SW_W-1:0] SW_LAST    = SW_W'(SWEEP_DIV - 1);
    localparam logic [SW_W-1:0] SW_ONE     = SW_W'(32'd1);
    localparam logic [7:0]      POS_MAX    = 8'(MAX_POS);
    localparam logic [7:0]      POS_CENTER = 8'(CENTER);

    typedef enum logic [0:0] {
        MODE_MANUAL = 1'b0,
        MODE_SWEEP  = 1'b1
    } mode_e;

    // Bit order for the three raw inputs: {A, B, button}
    logic [2:0]      raw_s;
    logic [2:0]      sync1_r;
    logic [2:0]      sync2_r;
    logic [2:0]      deb_r;
    logic [2:0]      deb_next_s;
    logic [DB_W-1:0] cnt_r      [3];
    logic [DB_W-1:0] cnt_next_s [3];

    logic [1:0]      ab_old_s;
    logic [1:0]      ab_new_s;
    logic            step_up_s;
    logic            step_dn_s;
    logic            enc_illegal_s;
    logic            btn_rise_s;

    mode_e           mode_r;
    mode_e           mode_next_s;
    logic            sweep_active_next_s;

    logic [SW_W-1:0] div_r;
    logic [SW_W-1:0] div_next_s;
    logic            dir_up_r;
    logic            dir_up_next_s;
    logic            sweep_up_s;
    logic            sweep_dir_up_s;
    logic [7:0]      sweep_pos_s;
    logic [7:0]      pos_r;
    logic [7:0]      pos_next_s;
    logic            pos_changed_r;
    logic            enc_error_r;
    logic            sweep_active_r;

    assign raw_s = {enc_a, enc_b, btn};

    // Two-flop synchronizers for the asynchronous raw inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-input debounce: the level must disagree for DEBOUNCE_CYCLES cycles in a row
    always_comb begin
        deb_next_s = deb_r;
        for (int i = 0; i < 3; i++) begin
            cnt_next_s[i] = cnt_r[i];
        end
        for (int i = 0; i < 3; i++) begin
            if (sync2_r[i] == deb_r[i]) begin
                cnt_next_s[i] = {DB_W{1'b0}};
            end else if (cnt_r[i] == DB_LAST) begin
                cnt_next_s[i] = {DB_W{1'b0}};
                deb_next_s[i] = sync2_r[i];
            end else begin
                cnt_next_s[i] = cnt_r[i] + DB_ONE;
            end
        end
    end

    // Debounced levels and their stability counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            deb_r <= deb_next_s;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    // Edge detection on the debounced levels; acting on the update lets position follow in the same edge
    always_comb begin
        ab_old_s      = deb_r[2:1];
        ab_new_s      = deb_next_s[2:1];
        enc_illegal_s = ((ab_old_s ^ ab_new_s) == 2'b11);
        step_up_s     = (ab_old_s == 2'b10) && (ab_new_s == 2'b00);
        step_dn_s     = (ab_old_s == 2'b01) && (ab_new_s == 2'b00);
        btn_rise_s    = ~deb_r[0] & deb_next_s[0];
    end

    // Mode state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= MODE_MANUAL;
        end else begin
            mode_r <= mode_next_s;
        end
    end

    // Mode next-state: each debounced button press toggles
    always_comb begin
        mode_next_s = mode_r;
        case (mode_r)
            MODE_MANUAL: begin
                if (btn_rise_s) begin
                    mode_next_s = MODE_SWEEP;
                end else begin
                    mode_next_s = MODE_MANUAL;
                end
            end
            MODE_SWEEP: begin
                if (btn_rise_s) begin
                    mode_next_s = MODE_MANUAL;
                end else begin
                    mode_next_s = MODE_SWEEP;
                end
            end
            default: mode_next_s = MODE_MANUAL;
        endcase
    end

    // Mode output decode, taken from the next state so the registered flag aligns with the mode
    always_comb begin
        case (mode_next_s)
            MODE_SWEEP:  sweep_active_next_s = 1'b1;
            MODE_MANUAL: sweep_active_next_s = 1'b0;
            default:     sweep_active_next_s = 1'b0;
        endcase
    end

    // Sweep step candidate: bounce off either end instead of overshooting
    always_comb begin
        sweep_up_s  = dir_up_r ? (pos_r < POS_MAX) : (pos_r == 8'd0);
        sweep_pos_s = sweep_up_s ? (pos_r + 8'd1) : (pos_r - 8'd1);
        if (sweep_up_s) begin
            sweep_dir_up_s = (sweep_pos_s != POS_MAX);
        end else begin
            sweep_dir_up_s = (sweep_pos_s == 8'd0);
        end
    end

    // Position, sweep divider and direction next-state; a button edge consumes the cycle
    always_comb begin
        pos_next_s    = pos_r;
        div_next_s    = div_r;
        dir_up_next_s = dir_up_r;
        if (btn_rise_s) begin
            div_next_s = {SW_W{1'b0}};
        end else if (mode_r == MODE_SWEEP) begin
            if (div_r == SW_LAST) begin
                div_next_s    = {SW_W{1'b0}};
                pos_next_s    = sweep_pos_s;
                dir_up_next_s = sweep_dir_up_s;
            end else begin
                div_next_s = div_r + SW_ONE;
            end
        end else if (step_up_s && (pos_r < POS_MAX)) begin
            pos_next_s = pos_r + 8'd1;
        end else if (step_dn_s && (pos_r != 8'd0)) begin
            pos_next_s = pos_r - 8'd1;
        end else begin
            pos_next_s = pos_r;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r          <= POS_CENTER;
            div_r          <= {SW_W{1'b0}};
            dir_up_r       <= 1'b1;
            pos_changed_r  <= 1'b0;
            enc_error_r    <= 1'b0;
            sweep_active_r <= 1'b0;
        end else begin
            pos_r          <= pos_next_s;
            div_r          <= div_next_s;
            dir_up_r       <= dir_up_next_s;
            pos_changed_r  <= (pos_next_s != pos_r);
            enc_error_r    <= enc_illegal_s;
            sweep_active_r <= sweep_active_next_s;
        end
    end

    assign position     = pos_r;
    assign pos_changed  = pos_changed_r;
    assign enc_error    = enc_error_r;
    assign sweep_active = sweep_active_r;

endmodule

// File: tb/tb_servo_setpoint_encoder.sv
// Self-checking bench for servo_setpoint_encoder: a scoreboard queue of expected
// (position, cycle) pairs is filled by the stimulus tasks and drained on pos_changed.

module tb_servo_setpoint_encoder;

    localparam int DB   = 4;
    localparam int MAXP = 40;
    localparam int CTR  = 20;
    localparam int SDIV = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enc_a;
    logic       enc_b;
    logic       btn;
    logic [7:0] position;
    logic       pos_changed;
    logic       sweep_active;
    logic       enc_error;

    typedef struct {
        logic [7:0] pos;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc          = 0;
    int   total        = 0;
    int   passed       = 0;
    int   err_cnt      = 0;
    int   last_err_cyc = -1;
    int   pulse_cnt    = 0;
    int   m_pos        = CTR;
    bit   m_up         = 1'b1;

    servo_setpoint_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .MAX_POS        (MAXP),
        .CENTER         (CTR),
        .SWEEP_DIV      (SDIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enc_a       (enc_a),
        .enc_b       (enc_b),
        .btn         (btn),
        .position    (position),
        .pos_changed (pos_changed),
        .sweep_active(sweep_active),
        .enc_error   (enc_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every pos_changed pulse must match the next expected value and cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (enc_error === 1'b1) begin
                err_cnt++;
                last_err_cyc = cyc;
            end
            if (pos_changed === 1'b1) begin
                pulse_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pos_changed_unexpected: position=%0d at cycle %0d, no change expected", position, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (position !== mon_e.pos || cyc != mon_e.at)
                        $display("FAIL pos_changed: got %0d at cycle %0d, expected %0d at cycle %0d",
                                 position, cyc, mon_e.pos, mon_e.at);
                    else
                        passed++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    function automatic void sweep_model();
        if (m_up) begin
            if (m_pos >= MAXP) begin m_pos--; m_up = 1'b0; end
            else m_pos++;
        end else begin
            if (m_pos <= 0) begin m_pos++; m_up = 1'b1; end
            else m_pos--;
        end
        if (m_pos == MAXP) m_up = 1'b0;
        if (m_pos == 0) m_up = 1'b1;
    endfunction

    // One detent, each level held 10 cycles; optionally press the button on the final edge
    task automatic detent(input bit cw, input bit press, output int last_edge);
        logic [1:0] lvl;
        last_edge = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            case (k)
                0:       lvl = cw ? 2'b01 : 2'b10;
                1:       lvl = 2'b11;
                2:       lvl = cw ? 2'b10 : 2'b01;
                default: lvl = 2'b00;
            endcase
            {enc_a, enc_b} = lvl;
            if (k == 3) begin
                last_edge = cyc;
                if (press) begin
                    btn = 1'b1;
                end else if (cw && m_pos < MAXP) begin
                    m_pos++;
                    exp_q.push_back('{8'(m_pos), cyc + 6});
                end else if (!cw && m_pos > 0) begin
                    m_pos--;
                    exp_q.push_back('{8'(m_pos), cyc + 6});
                end
            end
            idle(9);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        m_pos = CTR;
        m_up  = 1'b1;
        idle(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0; btn = 1'b0;
        idle(3);
        total++;
        if (position !== 8'd20) $display("FAIL reset_position: got %0d expected 20", position); else passed++;
        total++;
        if ({pos_changed, sweep_active, enc_error} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {pos_changed, sweep_active, enc_error});
        else passed++;
        rst_n = 1'b1;
        idle(8);
        total++;
        if (position !== 8'd20 || pulse_cnt != 0)
            $display("FAIL reset_release: got position %0d pulses %0d expected 20 and 0", position, pulse_cnt);
        else passed++;
    endtask

    task automatic test_glitch();
        int p0, e0;
        p0 = pulse_cnt; e0 = err_cnt;
        @(negedge clk); enc_a = 1'b1;
        idle(2);
        @(negedge clk); enc_a = 1'b0;
        idle(12);
        total++;
        if (position !== 8'd20 || pulse_cnt != p0 || err_cnt != e0)
            $display("FAIL glitch: got position %0d pulses %0d errors %0d expected 20, 0, 0",
                     position, pulse_cnt - p0, err_cnt - e0);
        else passed++;
    endtask

    task automatic test_single_detent();
        int p0, le;
        p0 = pulse_cnt;
        detent(1'b1, 1'b0, le);
        idle(3);
        total++;
        if (position !== 8'd21 || pulse_cnt != p0 + 1)
            $display("FAIL single_detent: got position %0d pulses %0d expected 21 and 1", position, pulse_cnt - p0);
        else passed++;
    endtask

    task automatic test_saturation();
        int p0, le;
        apply_reset();
        p0 = pulse_cnt;
        for (int i = 0; i < 25; i++) detent(1'b1, 1'b0, le);
        idle(3);
        total++;
        if (position !== 8'd40 || pulse_cnt != p0 + 20)
            $display("FAIL saturate_max: got position %0d pulses %0d expected 40 and 20", position, pulse_cnt - p0);
        else passed++;
        p0 = pulse_cnt;
        for (int i = 0; i < 41; i++) detent(1'b0, 1'b0, le);
        idle(3);
        total++;
        if (position !== 8'd0 || pulse_cnt != p0 + 40)
            $display("FAIL saturate_zero: got position %0d pulses %0d expected 0 and 40", position, pulse_cnt - p0);
        else passed++;
    endtask

    task automatic test_illegal();
        int e0, p0, c;
        e0 = err_cnt; p0 = pulse_cnt;
        @(negedge clk); {enc_a, enc_b} = 2'b11; c = cyc;
        idle(12);
        total++;
        if (err_cnt != e0 + 1 || last_err_cyc != c + 6)
            $display("FAIL illegal_error: got %0d pulses last at %0d expected 1 at %0d", err_cnt - e0, last_err_cyc, c + 6);
        else passed++;
        total++;
        if (position !== 8'd0 || pulse_cnt != p0)
            $display("FAIL illegal_position: got %0d pulses %0d expected 0 and 0", position, pulse_cnt - p0);
        else passed++;
        @(negedge clk); {enc_a, enc_b} = 2'b00;
        idle(12);
        total++;
        if (err_cnt != e0 + 2 || position !== 8'd0)
            $display("FAIL illegal_return: got errors %0d position %0d expected 2 and 0", err_cnt - e0, position);
        else passed++;
    endtask

    task automatic test_sweep();
        int t, t2, e, le;
        for (int i = 0; i < 38; i++) detent(1'b1, 1'b0, le);
        idle(2);
        @(negedge clk); btn = 1'b1; t = cyc; e = t + 6;
        for (int k = 1; k <= 4; k++) begin
            sweep_model();
            exp_q.push_back('{8'(m_pos), e + SDIV * k});
        end
        wait_to(e - 1);
        total++;
        if (sweep_active !== 1'b0) $display("FAIL sweep_pre: got %b expected 0", sweep_active); else passed++;
        wait_to(e);
        total++;
        if (sweep_active !== 1'b1) $display("FAIL sweep_enter: got %b expected 1", sweep_active); else passed++;
        wait_to(t + 10); btn = 1'b0;
        wait_to(e + 32);
        btn = 1'b1; t2 = cyc;
        wait_to(t2 + 6);
        total++;
        if (sweep_active !== 1'b0) $display("FAIL sweep_exit: got %b expected 0", sweep_active); else passed++;
        wait_to(t2 + 10); btn = 1'b0;
        wait_to(e + 52);
        total++;
        if (position !== 8'd38 || exp_q.size() != 0)
            $display("FAIL sweep_hold: got position %0d pending %0d expected 38 and 0", position, exp_q.size());
        else passed++;
        detent(1'b1, 1'b0, le);
        idle(2);
        total++;
        if (position !== 8'd39) $display("FAIL manual_resume: got %0d expected 39", position); else passed++;
    endtask

    task automatic test_reset_mid_sweep();
        int t, e;
        @(negedge clk); btn = 1'b1; t = cyc; e = t + 6;
        for (int k = 1; k <= 6; k++) begin
            sweep_model();
            exp_q.push_back('{8'(m_pos), e + SDIV * k});
        end
        wait_to(t + 10); btn = 1'b0;
        wait_to(e + 50);
        total++;
        if (position !== 8'd33) $display("FAIL sweep_down: got %0d expected 33", position); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (position !== 8'd20 || sweep_active !== 1'b0)
            $display("FAIL async_reset: got position %0d sweep %b expected 20 and 0", position, sweep_active);
        else passed++;
        idle(3);
        rst_n = 1'b1;
        m_pos = CTR; m_up = 1'b1;
        idle(2);
        @(negedge clk); btn = 1'b1; t = cyc; e = t + 6;
        for (int k = 1; k <= 2; k++) begin
            sweep_model();
            exp_q.push_back('{8'(m_pos), e + SDIV * k});
        end
        wait_to(t + 10); btn = 1'b0;
        wait_to(e + 18);
        btn = 1'b1;
        wait_to(e + 28); btn = 1'b0;
        wait_to(e + 40);
        total++;
        if (position !== 8'd22 || sweep_active !== 1'b0 || exp_q.size() != 0)
            $display("FAIL sweep_up_after_reset: got position %0d sweep %b pending %0d expected 22, 0, 0",
                     position, sweep_active, exp_q.size());
        else passed++;
    endtask

    task automatic test_back_to_back();
        int p0, e, le;
        p0 = pulse_cnt;
        detent(1'b1, 1'b1, le);
        e = le + 6;
        total++;
        if (position !== 8'd22 || sweep_active !== 1'b1)
            $display("FAIL collision: got position %0d sweep %b expected 22 and 1", position, sweep_active);
        else passed++;
        for (int k = 1; k <= 2; k++) begin
            sweep_model();
            exp_q.push_back('{8'(m_pos), e + SDIV * k});
        end
        @(negedge clk); btn = 1'b0;
        wait_to(le + 17); btn = 1'b1;
        wait_to(le + 27); btn = 1'b0;
        wait_to(le + 45);
        total++;
        if (position !== 8'd24 || sweep_active !== 1'b0 || pulse_cnt != p0 + 2)
            $display("FAIL collision_sweep: got position %0d sweep %b pulses %0d expected 24, 0, 2",
                     position, sweep_active, pulse_cnt - p0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single_detent();
        test_saturation();
        test_illegal();
        test_sweep();
        test_reset_mid_sweep();
        test_back_to_back();
        idle(4);
        total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
